fir_serial_mac: RTL
===================

// Module: fir_serial_mac
// PURPOSE
//  Time-multiplexed direct-form FIR: one multiplier/accumulator serves all NTAPS taps per input sample.
//  Produces the full-precision signed accumulator word that feeds the saturate/truncate stage (SatTruncFP).
//  The output format is NB_ACC bits with NBF_ACC fractional bits; these become that stage's NB_XI/NBF_XI.
// PARAMETERS
//  NB_X      8   input sample width, signed
//  NBF_X     6   input fractional bits
//  NB_COEF   8   coefficient width, signed
//  NBF_COEF  7   coefficient fractional bits
//  NTAPS     4   number of taps, >=2
//  localparam NB_CNT  = $clog2(NTAPS)
//  localparam NB_ACC  = NB_X+NB_COEF+NB_CNT
//  localparam NBF_ACC = NBF_X+NBF_COEF
// PORTS
//  i_clock    in   1               clock, rising edge
//  i_reset_n  in   1               asynchronous, active-low reset
//  i_data     in   NB_X            input sample
//  i_valid    in   1               sample present
//  o_ready    out  1               block can accept a sample this cycle
//  i_coeffs   in   NTAPS*NB_COEF   h[k] = i_coeffs[k*NB_COEF +: NB_COEF]; static while o_ready=0
//  o_data     out  NB_ACC          filter output, full precision
//  o_valid    out  1               one-cycle pulse, o_data is valid
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, delay line x[0..NTAPS-1]=0, acc=0, cnt=0,
//   o_data=0, o_valid=0. o_ready=1 after reset.
//  FSM:
//   IDLE: o_ready=1.
//    If i_valid: shift the delay line (x[k]<=x[k-1], x[0]<=i_data), acc<=0, cnt<=0, go to MAC.
//   MAC: o_ready=0. Each cycle acc<=acc+sext(x[cnt]*h[cnt]) and cnt<=cnt+1.
//    When cnt==NTAPS-1, go to DONE after that accumulate.
//   DONE: o_data<=acc, o_valid=1 for this cycle only, go to IDLE.
//  o_data holds its last value until the next DONE.
//  Timing: accept at cycle T; MAC occupies T+1..T+NTAPS; o_valid=1 at T+NTAPS+1.
//   Max throughput is 1 sample per NTAPS+2 cycles. A new sample may be accepted in the cycle after DONE.
//  Arithmetic: signed NB_X x NB_COEF product, NB_X+NB_COEF bits, fraction NBF_ACC.
//   Sign-extend the product to NB_ACC before adding.
//   The NB_CNT guard bits make overflow impossible, including all operands at most-negative.
//   No rounding or saturation here; that is the downstream stage's job.
//  i_valid while o_ready=0 is ignored; the sample is dropped and the delay line is not modified.
//  Reset mid-MAC: return to IDLE and clear the delay line. No o_valid pulse for the aborted sample.
//  cnt never exceeds NTAPS-1. No wrap-around read of x/h beyond index NTAPS-1.
// STRUCTURE
//  Shared include fir_defs.vh:
//   state encodings FIR_IDLE=2'd0, FIR_MAC=2'd1, FIR_DONE=2'd2
//   clog2 helper, and the NB_ACC/NBF_ACC formulas so SatTruncFP instances use identical widths.
//  One sub-module, fir_mac_unit:
//   signed multiply, sign-extend, accumulate register with clear and enable.
//  The top level holds the FSM, tap counter, delay line and coefficient/sample muxes.
// TESTING (NB_X=8,NBF_X=6,NB_COEF=8,NBF_COEF=7,NTAPS=4; h={0x10,0x20,0x30,0x40}, h[0]=0x10)
//  1. Impulse: 0x40 then three 0x00 samples -> o_data = 0x00400, 0x00800, 0x00C00, 0x01000 (18-bit).
//  2. Worst case: four samples 0x80, all h=0x80 -> fourth o_data = 0x10000 (+65536), no overflow.
//  3. Latency/throughput: i_valid held high -> accepts every 6th cycle.
//     o_valid exactly 5 cycles after each accept; o_ready low during MAC/DONE.
//  4. Busy drop: i_valid=1 with 0x7F during MAC -> no change in the delay line; next output as if 0x7F never came.
//  5. Negative: one sample 0xC0 (-1.0), h[0]=0x10 -> o_data = 0x3FC00 (-1024).
//  6. Reset mid-MAC: assert i_reset_n=0 in the 2nd MAC cycle -> o_valid stays 0, o_data=0, o_ready=1 after release.
//     Next impulse reproduces scenario 1.

Source files
------------

// File: rtl/fir_serial_mac_pkg.sv
// rtl/fir_serial_mac_pkg.sv - shared FSM encoding and width helpers for the serial FIR MAC
package fir_serial_mac_pkg;

  typedef enum logic [1:0] {
    FIR_IDLE = 2'd0,
    FIR_MAC  = 2'd1,
    FIR_DONE = 2'd2
  } fir_state_t;

  function automatic int fir_clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // The downstream saturate/truncate stage derives its input widths from these same formulas.
  function automatic int fir_nb_acc(input int nb_x, input int nb_coef, input int ntaps);
    return nb_x + nb_coef + fir_clog2(ntaps);
  endfunction

  function automatic int fir_nbf_acc(input int nbf_x, input int nbf_coef);
    return nbf_x + nbf_coef;
  endfunction

endpackage

// File: rtl/fir_serial_mac_mac_unit.sv
// rtl/fir_serial_mac_mac_unit.sv - signed multiply, sign-extend and accumulate with clear/enable
module fir_mac_unit #(
  parameter int NB_X    = 8,
  parameter int NB_COEF = 8,
  parameter int NB_ACC  = 18
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic                     i_clear,
  input  logic                     i_enable,
  input  logic signed [NB_X-1:0]   i_x,
  input  logic signed [NB_COEF-1:0] i_h,
  output logic signed [NB_ACC-1:0] o_sum
);

  localparam int NB_PROD = NB_X + NB_COEF;

  logic signed [NB_PROD-1:0] w_prod;
  logic signed [NB_ACC-1:0]  w_prod_ext;
  logic signed [NB_ACC-1:0]  r_acc;

  assign w_prod     = i_x * i_h;
  assign w_prod_ext = {{(NB_ACC - NB_PROD){w_prod[NB_PROD-1]}}, w_prod};
  assign o_sum      = r_acc + w_prod_ext;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_enable) begin
      r_acc <= o_sum;
    end
  end

endmodule

// File: rtl/fir_serial_mac.sv
// rtl/fir_serial_mac.sv - time-multiplexed direct-form FIR, one MAC shared across all taps
module fir_serial_mac
  import fir_serial_mac_pkg::*;
#(
  parameter  int NB_X     = 8,
  parameter  int NBF_X    = 6,
  parameter  int NB_COEF  = 8,
  parameter  int NBF_COEF = 7,
  parameter  int NTAPS    = 4,
  localparam int NB_CNT   = fir_clog2(NTAPS),
  localparam int NB_ACC   = fir_nb_acc(NB_X, NB_COEF, NTAPS)
) (
  input  logic                       i_clock,
  input  logic                       i_reset_n,
  input  logic [NB_X-1:0]            i_data,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [NTAPS*NB_COEF-1:0]   i_coeffs,
  output logic [NB_ACC-1:0]          o_data,
  output logic                       o_valid
);

  localparam int NBF_ACC = fir_nbf_acc(NBF_X, NBF_COEF);

  if (NTAPS < 2) begin : g_bad_ntaps
    $error("fir_serial_mac: NTAPS must be at least 2");
  end
  if (NBF_ACC >= NB_ACC) begin : g_bad_frac
    $error("fir_serial_mac: fractional bits exceed accumulator width");
  end

  fir_state_t r_state;
  fir_state_t w_state_next;

  logic [NB_X-1:0]    r_x [NTAPS];
  logic [NB_CNT-1:0]  r_cnt;
  logic [NB_ACC-1:0]  r_data;

  logic               w_accept;
  logic               w_last;
  logic               w_mac_en;
  logic [NB_X-1:0]    w_x_sel;
  logic [NB_COEF-1:0] w_h_sel;
  logic [NB_ACC-1:0]  w_sum;

  assign w_accept = (r_state == FIR_IDLE) && i_valid;
  assign w_mac_en = (r_state == FIR_MAC);
  assign w_last   = (r_cnt == NB_CNT'(NTAPS - 1));
  assign w_x_sel  = r_x[r_cnt];
  assign w_h_sel  = i_coeffs[r_cnt*NB_COEF +: NB_COEF];

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= FIR_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FIR_IDLE: if (i_valid) w_state_next = FIR_MAC;
      FIR_MAC:  if (w_last)  w_state_next = FIR_DONE;
      FIR_DONE: w_state_next = FIR_IDLE;
      default:  w_state_next = FIR_IDLE;
    endcase
  end

  always_comb begin
    o_ready = 1'b0;
    o_valid = 1'b0;
    case (r_state)
      FIR_IDLE: o_ready = 1'b1;
      FIR_DONE: o_valid = 1'b1;
      default:  ;
    endcase
  end

  // The final sum is captured on the last MAC cycle so o_data is already valid during DONE.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int k = 0; k < NTAPS; k++) r_x[k] <= '0;
      r_cnt  <= '0;
      r_data <= '0;
    end else begin
      if (w_accept) begin
        for (int k = NTAPS - 1; k > 0; k--) r_x[k] <= r_x[k-1];
        r_x[0] <= i_data;
        r_cnt  <= '0;
      end else if (w_mac_en && !w_last) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_mac_en && w_last) begin
        r_data <= w_sum;
      end
    end
  end

  assign o_data = r_data;

  fir_mac_unit #(
    .NB_X    (NB_X),
    .NB_COEF (NB_COEF),
    .NB_ACC  (NB_ACC)
  ) u_mac (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_clear   (w_accept),
    .i_enable  (w_mac_en),
    .i_x       (w_x_sel),
    .i_h       (w_h_sel),
    .o_sum     (w_sum)
  );

endmodule
